// File: rtl/dct_pkg.sv
// Shared types and constants for the 8x8 forward DCT: state encoding,
// 8-point DCT-II coefficient ROM (7 fractional bits) and accumulator sizing.
package dct_pkg;

  typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_t;

  localparam int COEF_W = 9;

  // DCT_COEF[k][n] = round(128 * a_k * cos((2n+1) k pi / 16))
  localparam logic signed [COEF_W-1:0] DCT_COEF [8][8] = '{
    '{ 9'sd45,  9'sd45,  9'sd45,  9'sd45,  9'sd45,  9'sd45,  9'sd45,  9'sd45},
    '{ 9'sd63,  9'sd53,  9'sd36,  9'sd12, -9'sd12, -9'sd36, -9'sd53, -9'sd63},
    '{ 9'sd59,  9'sd24, -9'sd24, -9'sd59, -9'sd59, -9'sd24,  9'sd24,  9'sd59},
    '{ 9'sd53, -9'sd12, -9'sd63, -9'sd36,  9'sd36,  9'sd63,  9'sd12, -9'sd53},
    '{ 9'sd45, -9'sd45, -9'sd45,  9'sd45,  9'sd45, -9'sd45, -9'sd45,  9'sd45},
    '{ 9'sd36, -9'sd63,  9'sd12,  9'sd53, -9'sd53, -9'sd12,  9'sd63, -9'sd36},
    '{ 9'sd24, -9'sd59,  9'sd59, -9'sd24, -9'sd24,  9'sd59, -9'sd59,  9'sd24},
    '{ 9'sd12, -9'sd36,  9'sd53, -9'sd63,  9'sd63, -9'sd53,  9'sd36, -9'sd12}
  };

  function automatic int acc_width(input int value_width);
    return value_width + 11;
  endfunction

endpackage

// File: rtl/dct_dot8.sv
// Combinational 8-term signed dot product with floor shift and saturation;
// shared by the row and column passes.
module dct_dot8
  import dct_pkg::*;
#(
  parameter int VALUE_WIDTH = 17,
  parameter int SCALE       = 7
) (
  input  logic signed [VALUE_WIDTH-1:0] i_a [8],
  input  logic signed [COEF_W-1:0]      i_c [8],
  output logic signed [VALUE_WIDTH-1:0] o_y
);

  localparam int ACC_W  = acc_width(VALUE_WIDTH);
  localparam int PROD_W = VALUE_WIDTH + COEF_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(VALUE_WIDTH-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [PROD_W-1:0] w_prod [8];
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W-1:0]  w_shift;

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < 8; k++) begin
      w_prod[k] = PROD_W'(i_a[k]) * PROD_W'(i_c[k]);
      w_acc     = w_acc + ACC_W'(w_prod[k]);
    end
  end

  assign w_shift = w_acc >>> SCALE;

  always_comb begin
    o_y = w_shift[VALUE_WIDTH-1:0];
    if (w_shift > SAT_MAX)      o_y = SAT_MAX[VALUE_WIDTH-1:0];
    else if (w_shift < SAT_MIN) o_y = SAT_MIN[VALUE_WIDTH-1:0];
  end

endmodule

// File: rtl/two_dimension_dct.sv
// 8x8 forward 2-D DCT: buffers one block, runs a row pass then a column pass
// through a shared dot-product unit, and streams coefficients column-major.
//   state | meaning
//   LOAD  | accept 64 row-major samples into the input buffer
//   ROW   | Y[i][v], one per cycle, into the row buffer
//   COL   | Z[u][v], computed directly in output order
//   OUT   | stream 64 coefficients, TLAST on the last
module two_dimension_dct
  import dct_pkg::*;
#(
  parameter int VALUE_WIDTH     = 17,
  parameter int SCALE           = 7,
  parameter int AXIS_DATA_WIDTH = 8 * ((VALUE_WIDTH - 1) / 8 + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_axis_TVALID,
  output logic                       o_axis_TREADY,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_TDATA,
  input  logic                       i_axis_TLAST,
  output logic                       o_axis_TVALID,
  input  logic                       i_axis_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_TDATA,
  output logic                       o_axis_TLAST
);

  state_t r_state, w_next_state;
  logic [5:0] r_cnt;
  logic signed [VALUE_WIDTH-1:0] r_xbuf [64];
  logic signed [VALUE_WIDTH-1:0] r_ybuf [64];
  logic signed [VALUE_WIDTH-1:0] r_zbuf [64];
  logic r_tready, r_tvalid, r_tlast;
  logic [AXIS_DATA_WIDTH-1:0] r_tdata;

  logic signed [VALUE_WIDTH-1:0] w_dot_a [8];
  logic signed [COEF_W-1:0]      w_dot_c [8];
  logic signed [VALUE_WIDTH-1:0] w_dot_y;
  logic w_in_hs, w_out_done, w_out_load;
  logic w_unused_in;

  // Framing is purely by count, so TLAST and the pad bits are don't-cares.
  assign w_unused_in = ^{i_axis_TLAST, i_axis_TDATA};

  assign w_in_hs    = i_axis_TVALID & r_tready;
  assign w_out_done = r_tvalid & r_tlast & i_axis_TREADY;
  assign w_out_load = (r_state == OUT) & (~r_tvalid | i_axis_TREADY);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= LOAD;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LOAD:    if (w_in_hs && r_cnt == 6'd63) w_next_state = ROW;
      ROW:     if (r_cnt == 6'd63) w_next_state = COL;
      COL:     if (r_cnt == 6'd63) w_next_state = OUT;
      OUT:     if (w_out_done) w_next_state = LOAD;
      default: w_next_state = LOAD;
    endcase
  end

  // Row pass: i = cnt[5:3], v = cnt[2:0]. Column pass: v = cnt[5:3], u = cnt[2:0].
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_dot_c[k] = DCT_COEF[r_cnt[2:0]][3'(k)];
      if (r_state == COL) w_dot_a[k] = r_ybuf[{3'(k), r_cnt[5:3]}];
      else                w_dot_a[k] = r_xbuf[{r_cnt[5:3], 3'(k)}];
    end
  end

  dct_dot8 #(
    .VALUE_WIDTH(VALUE_WIDTH),
    .SCALE      (SCALE)
  ) u_dot8 (
    .i_a(w_dot_a),
    .i_c(w_dot_c),
    .o_y(w_dot_y)
  );

  always_ff @(posedge i_clk) begin
    if (r_state == LOAD && w_in_hs) r_xbuf[r_cnt] <= $signed(i_axis_TDATA[VALUE_WIDTH-1:0]);
    if (r_state == ROW)             r_ybuf[r_cnt] <= w_dot_y;
    if (r_state == COL)             r_zbuf[r_cnt] <= w_dot_y;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_tready <= 1'b0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else begin
      r_tready <= (w_next_state == LOAD);
      case (r_state)
        LOAD: if (w_in_hs) r_cnt <= r_cnt + 6'd1;
        ROW,
        COL:  r_cnt <= r_cnt + 6'd1;
        OUT: begin
          if (w_out_done) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_cnt    <= '0;
          end else if (w_out_load) begin
            r_tdata  <= AXIS_DATA_WIDTH'(r_zbuf[r_cnt]);
            r_tvalid <= 1'b1;
            r_tlast  <= (r_cnt == 6'd63);
            r_cnt    <= r_cnt + 6'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_axis_TREADY = r_tready;
  assign o_axis_TVALID = r_tvalid;
  assign o_axis_TDATA  = r_tdata;
  assign o_axis_TLAST  = r_tlast;

endmodule

// File: tb/tb_two_dimension_dct.sv
// Directed bench for two_dimension_dct: hand-computed coefficient sets for
// ramp, zero, constant and negated-ramp blocks, with stalls, gaps and reset.
module tb_two_dimension_dct;

  localparam int VW = 17;
  localparam int AW = 24;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_axis_TVALID;
  logic          o_axis_TREADY;
  logic [AW-1:0] i_axis_TDATA;
  logic          i_axis_TLAST;
  logic          o_axis_TVALID;
  logic          i_axis_TREADY;
  logic [AW-1:0] o_axis_TDATA;
  logic          o_axis_TLAST;

  int checks   = 0;
  int failures = 0;
  int exp_z [64];
  int got   [64];

  two_dimension_dct dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_axis_TVALID(i_axis_TVALID),
    .o_axis_TREADY(o_axis_TREADY),
    .i_axis_TDATA (i_axis_TDATA),
    .i_axis_TLAST (i_axis_TLAST),
    .o_axis_TVALID(o_axis_TVALID),
    .i_axis_TREADY(i_axis_TREADY),
    .o_axis_TDATA (o_axis_TDATA),
    .o_axis_TLAST (o_axis_TLAST)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // kind: 0 ramp, 1 zeros, 2 constant 1.0, 3 negated ramp
  function automatic int sample_val(input int kind, input int n);
    case (kind)
      0:       return (n + 1) * 128;
      1:       return 0;
      2:       return 128;
      default: return -(n + 1) * 128;
    endcase
  endfunction

  function automatic void set_expected(input int kind);
    for (int m = 0; m < 64; m++) exp_z[m] = 0;
    case (kind)
      0: begin
        exp_z[0]  = 32906; exp_z[1]  = -18585; exp_z[3]  = -1935; exp_z[5] = -585;
        exp_z[8]  = -2324; exp_z[24] = -242;   exp_z[40] = -74;
      end
      2: exp_z[0] = 1012;
      3: begin
        exp_z[0]  = -32907; exp_z[1]  = 18585; exp_z[3]  = 1935; exp_z[5] = 585;
        exp_z[8]  = 2323;   exp_z[24] = 241;   exp_z[40] = 73;
      end
      default: ;
    endcase
  endfunction

  task automatic send_block(input int kind, input int gapped, input int count);
    int n;
    int guard;
    logic hs;
    n = 0;
    guard = 0;
    while (n < count && guard < 1000) begin
      guard++;
      if (gapped != 0 && (guard % 3) == 0) begin
        i_axis_TVALID = 1'b0;
        tick();
      end else begin
        i_axis_TVALID = 1'b1;
        i_axis_TDATA  = {7'h55, 17'(sample_val(kind, n))};
        i_axis_TLAST  = (n == 63);
        hs = o_axis_TREADY;
        tick();
        if (hs) n++;
      end
    end
    i_axis_TVALID = 1'b0;
    i_axis_TLAST  = 1'b0;
    chk("send_count", n, count);
  endtask

  task automatic wait_first_out(input string tag);
    int lat;
    int rdy_bad;
    lat = 0;
    rdy_bad = 0;
    while (!o_axis_TVALID && lat < 400) begin
      if (o_axis_TREADY) rdy_bad++;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 129);
    chk({tag, "_tready_low_busy"}, rdy_bad, 0);
  endtask

  task automatic recv_block(input int stall, input string tag);
    int m;
    int cyc;
    int hold_bad;
    int rdy_bad;
    int d;
    int prev_d;
    logic l;
    logic prev_l;
    logic held;
    logic rdy;
    m = 0; cyc = 0; hold_bad = 0; rdy_bad = 0;
    prev_d = 0; prev_l = 1'b0; held = 1'b0;
    while (m < 64 && cyc < 3000) begin
      cyc++;
      rdy = (stall != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_axis_TREADY = rdy;
      if (o_axis_TREADY) rdy_bad++;
      if (o_axis_TVALID) begin
        d = int'($signed(o_axis_TDATA));
        l = o_axis_TLAST;
        if (held && (d != prev_d || l != prev_l)) hold_bad++;
        if (rdy) begin
          chk($sformatf("%s_m%0d", tag, m), d, exp_z[m]);
          chk($sformatf("%s_tlast%0d", tag, m), int'(l), (m == 63) ? 1 : 0);
          got[m] = d;
          m++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          prev_d = d;
          prev_l = l;
        end
      end
      tick();
    end
    i_axis_TREADY = 1'b1;
    chk({tag, "_count"}, m, 64);
    chk({tag, "_stall_hold"}, hold_bad, 0);
    chk({tag, "_tready_low_out"}, rdy_bad, 0);
    chk({tag, "_tready_after"}, int'(o_axis_TREADY), 1);
    chk({tag, "_tvalid_after"}, int'(o_axis_TVALID), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset       = 1'b1;
    i_axis_TVALID = 1'b0;
    i_axis_TDATA  = '0;
    i_axis_TLAST  = 1'b0;
    i_axis_TREADY = 1'b1;
    tick(); tick(); tick();
    chk("rst_tready", int'(o_axis_TREADY), 0);
    chk("rst_tvalid", int'(o_axis_TVALID), 0);
    chk("rst_tlast",  int'(o_axis_TLAST), 0);
    chk("rst_tdata",  int'(o_axis_TDATA), 0);
    i_reset = 1'b0;
    tick();
    chk("rst_tready_rise", int'(o_axis_TREADY), 1);

    // Ramp, downstream always ready
    set_expected(0);
    send_block(0, 0, 64);
    wait_first_out("ramp");
    recv_block(0, "ramp");
    chk("ramp_m0_int", got[0] >>> 7, 257);
    chk("ramp_m1_int", got[1] >>> 7, -146);

    set_expected(1);
    send_block(1, 0, 64);
    wait_first_out("zero");
    recv_block(0, "zero");

    set_expected(2);
    send_block(2, 0, 64);
    wait_first_out("const");
    recv_block(0, "const");

    // Ramp with random downstream stalls
    set_expected(0);
    send_block(0, 0, 64);
    wait_first_out("stall");
    recv_block(1, "stall");

    // Ramp with gapped input valid
    send_block(0, 1, 64);
    wait_first_out("gap");
    recv_block(0, "gap");

    // Reset after 30 samples, then a fresh ramp
    send_block(3, 0, 30);
    i_reset = 1'b1;
    tick();
    chk("midrst_tready", int'(o_axis_TREADY), 0);
    chk("midrst_tvalid", int'(o_axis_TVALID), 0);
    chk("midrst_tdata",  int'(o_axis_TDATA), 0);
    i_reset = 1'b0;
    tick();
    chk("midrst_tready_rise", int'(o_axis_TREADY), 1);
    chk("midrst_tvalid_idle", int'(o_axis_TVALID), 0);
    send_block(0, 0, 64);
    wait_first_out("postrst");
    recv_block(0, "postrst");

    // Back-to-back: ramp then negated ramp
    send_block(0, 0, 64);
    wait_first_out("b2b_a");
    recv_block(0, "b2b_a");
    set_expected(3);
    send_block(3, 0, 64);
    wait_first_out("b2b_b");
    recv_block(0, "b2b_b");
    chk("neg_m1", got[1], 18585);
    chk("neg_m0", got[0], -32907);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/two_dimension_dct.md
Name: two_dimension_dct

Overview:
- 8x8 forward 2-D DCT-II on one block of signed fixed-point samples (SCALE fractional bits).
- Separable row pass then column pass, each using 8-point integer DCT coefficients with 7 fractional bits.
- AXI-Stream slave in and AXI-Stream master out.
- Sits between the pixel/residual block former and the quantiser in the H.263 encoder datapath.

Parameters:
- VALUE_WIDTH, 17: signed sample/coefficient width (two's complement) in and out.
- SCALE, 7: fractional bits of sample values; also the post-accumulate right shift.
- AXIS_DATA_WIDTH, 8*((VALUE_WIDTH-1)/8+1): byte-rounded TDATA width (24 by default).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_axis_TVALID  in  1  input sample valid.
- o_axis_TREADY  out  1  block can accept an input sample.
- i_axis_TDATA  in  AXIS_DATA_WIDTH  sample; bits [VALUE_WIDTH-1:0] used; upper bits ignored.
- i_axis_TLAST  in  1  last sample of block; informational only.
- o_axis_TVALID  out  1  output coefficient valid.
- i_axis_TREADY  in  1  downstream ready.
- o_axis_TDATA  out  AXIS_DATA_WIDTH  coefficient, sign-extended from VALUE_WIDTH.
- o_axis_TLAST  out  1  high with the 64th coefficient.

Behaviour:
- Reset (synchronous, i_reset=1 at the clock edge): state=LOAD, all counters 0, o_axis_TREADY=0, o_axis_TVALID=0, o_axis_TLAST=0, o_axis_TDATA=0. o_axis_TREADY rises in the first LOAD cycle after reset.
- Reset mid-operation discards the partial block; no partial output is produced.
- Input order: row-major, sample n -> x[i][j] with i=n/8, j=n%8.
- Input transfer occurs on TVALID&TREADY.
- Framing is by a 6-bit counter only; TLAST is not used to close or realign a block.

FSM:
- LOAD: TREADY=1. Store samples into a 64-entry buffer. Go to ROW on the 64th handshake, with TREADY=0 from the next cycle.
- ROW: 64 cycles, one output per cycle. Y[i][v] = (sum_j C[v][j]*x[i][j]) >>> SCALE.
- COL: 64 cycles. Z[u][v] = (sum_i C[u][i]*Y[i][v]) >>> SCALE.
- OUT: TVALID=1 and stream 64 coefficients. Advance only on TVALID&i_axis_TREADY; hold TDATA/TLAST stable while stalled. After the 64th transfer go to LOAD.
- First o_axis_TVALID occurs 129 cycles after the last input handshake.

Arithmetic:
- Coefficient ROM: C[k][n] = round(128*a_k*cos((2n+1)k*pi/16)), with a_0=sqrt(1/8) and a_k=1/2 otherwise.
- Magnitudes: k0 45; then 63, 59, 53, 45, 36, 24, 12 (the value for k uses cos(k*pi/16)), with the sign of the cosine.
- Products are full width. Accumulate in VALUE_WIDTH+11 bits, then arithmetic shift right SCALE (floor).
- Saturate to the signed VALUE_WIDTH range after each pass.

Output:
- Column-major: output index m carries Z[u][v] with u=m%8 (vertical frequency) and v=m/8 (horizontal frequency).
- o_axis_TLAST=1 on m=63.

Decomposition:
- Package dct_pkg: 8x8 coefficient ROM constant (localparam signed [8:0] array), state enum (LOAD, ROW, COL, OUT), accumulator width function.
- Sub-module dct_dot8: 8 parallel signed multipliers plus adder tree plus shift/saturate. Combinational, instantiated once and shared between the ROW and COL passes.

Test Plan:
- Ramp x[i][j]=(8i+j+1)<<7 with downstream always ready.
  - Raw outputs: m0=32906, m1=-18585, m3=-1935, m5=-585, m8=-2324, m24=-242, m40=-74; all others 0.
  - TLAST on m63.
  - Value >>>7: m0=257, m1=-146.
- All samples 0 -> 64 zeros. Constant 128 (1.0) -> m0=(45*45*8*8*128/128)>>>7 = 1012, rest 0.
- Random i_axis_TREADY deassertion during OUT:
  - Same sequence as the ramp case, with no drop or duplicate.
  - TDATA/TLAST stable while stalled.
- Gapped i_axis_TVALID during LOAD: result identical to the ramp case. o_axis_TREADY=0 from ROW entry until OUT completes.
- i_reset asserted after 30 input samples: outputs idle, o_axis_TREADY=1 the next cycle. A fresh ramp block then produces the ramp results.
- Back-to-back blocks (ramp then negated ramp): the second block's m1=+18585 and m0=-32907.
